// File: rtl/banked_mem_responder.sv
// Four-bank, word-interleaved 16-bit main memory responder.
// Each accepted access holds its bank busy for BANK_CYCLES cycles; read data returns two cycles after accept.
module banked_mem_responder #(
    parameter int MEM_AW      = 12,
    parameter int BANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);
    localparam int WORDS = 2 ** MEM_AW;

    logic [15:0]       mem [WORDS];
    logic [1:0]        bank;
    logic [MEM_AW-1:0] word;
    logic              req;
    logic              accept;
    logic              s1_valid;
    logic [15:0]       s1_data;

    // Upper address bits above the word index wrap onto the same storage.
    wire unused_addr = &{1'b0, addr[15:MEM_AW+1]};

    assign bank = addr[2:1];
    assign word = addr[MEM_AW:1];

    // Handshake: the initiator holds rd/wr until accepted; accept = req & ~err & ~stall.
    // Errored or stalled requests leave no trace in storage, counters or the read path.
    always_comb begin
        req    = rd | wr;
        err    = req & ((rd & wr) | addr[0]);
        stall  = req & ~err & busy[bank];
        accept = req & ~err & ~stall;
    end

    for (genvar g = 0; g < 4; g++) begin : g_bank
        logic [2:0] cnt;

        // Loading BANK_CYCLES keeps busy high for exactly BANK_CYCLES cycles after accept.
        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt <= 3'd0;
            end else if (accept && (bank == 2'(g))) begin
                cnt <= 3'(BANK_CYCLES);
            end else if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end

        assign busy[g] = (cnt != 3'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i[MEM_AW-1:0]] <= 16'h0000;
            end
        end else if (accept && wr) begin
            mem[word] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1_data    <= 16'h0000;
            data_valid <= 1'b0;
            data_out   <= 16'h0000;
        end else begin
            s1_valid   <= accept & rd;
            if (accept && rd) begin
                s1_data <= mem[word];
            end
            data_valid <= s1_valid;
            if (s1_valid) begin
                data_out <= s1_data;
            end
        end
    end
endmodule

// File: tb/tb_banked_mem_responder.sv
// Self-checking bench for banked_mem_responder: directed scenarios plus randomized traffic
// checked against a cycle-numbered reference model of memory, bank windows and read returns.
module tb_banked_mem_responder;
    localparam int MEM_AW      = 12;
    localparam int BANK_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] data_in = 16'h0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] data_out;
    logic        data_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    banked_mem_responder #(.MEM_AW(MEM_AW), .BANK_CYCLES(BANK_CYCLES)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
        .data_out(data_out), .data_valid(data_valid), .stall(stall), .busy(busy), .err(err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [15:0] model_mem [2**MEM_AW];
    int          bank_until [4];
    logic [15:0] exp_q [$];
    int          due_q [$];
    logic [15:0] last_data;
    logic        m_err, m_stall, m_acc, m_dv;
    logic [3:0]  m_busy;
    logic [15:0] m_dout;

    task automatic model_reset();
        foreach (model_mem[i]) model_mem[i] = 16'h0;
        foreach (bank_until[i]) bank_until[i] = -1;
        exp_q.delete();
        due_q.delete();
        last_data = 16'h0;
    endtask

    // Drives one cycle, then predicts this cycle's outputs and the state after its closing edge.
    task automatic drive(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic rs);
        int b;
        int wi;
        int dummy;
        @(posedge clk);
        #1;
        rd = r; wr = w; addr = a; data_in = d; rst = rs;
        cyc++;
        #1;
        b  = int'(a[2:1]);
        wi = int'(a[MEM_AW:1]);
        for (int k = 0; k < 4; k++) m_busy[k] = (cyc <= bank_until[k]);
        m_err   = (r | w) && ((r && w) || a[0]);
        m_stall = (r | w) && !m_err && m_busy[b];
        m_acc   = (r | w) && !m_err && !m_stall;
        m_dv    = (due_q.size() > 0) && (due_q[0] == cyc);
        m_dout  = m_dv ? exp_q[0] : last_data;
        if (!rs) begin
            model_reset();
        end else begin
            if (m_dv) begin
                last_data = exp_q.pop_front();
                dummy = due_q.pop_front();
            end
            if (m_acc) begin
                bank_until[b] = cyc + BANK_CYCLES;
                if (w) model_mem[wi] = d;
                else begin
                    exp_q.push_back(model_mem[wi]);
                    due_q.push_back(cyc + 2);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(0, 0, 16'h0, 16'h0, 0);
        drive(0, 0, 16'h0, 16'h0, 0);
        drive(0, 0, 16'h0, 16'h0, 1);
        n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL reset_busy: got %b expected 0000", busy); end
        n_cmp++; if (data_out !== 16'h0000) begin n_bad++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
        drive(1, 0, 16'h0010, 16'h0, 1);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_read_stall: got %b expected 0", stall); end
        idle(1);
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_read_early_valid: got %b expected 0", data_valid); end
        idle(1);
        n_cmp++; if (data_valid !== 1'b1 || data_out !== 16'h0000) begin
            n_bad++; $display("FAIL reset_read_data: got valid=%b data=%h expected valid=1 data=0000", data_valid, data_out); end
        idle(1);
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_read_valid_width: got %b expected 0", data_valid); end
    endtask

    task automatic test_write_read();
        idle(8);
        drive(0, 1, 16'h0006, 16'hBEEF, 1);
        n_cmp++; if (stall !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL wr_accept: got stall=%b err=%b expected 0 0", stall, err); end
        for (int i = 1; i <= BANK_CYCLES; i++) begin
            idle(1);
            n_cmp++; if (busy[3] !== 1'b1) begin n_bad++; $display("FAIL wr_busy3_cycle%0d: got %b expected 1", i, busy[3]); end
        end
        drive(1, 0, 16'h0006, 16'h0, 1);
        n_cmp++; if (busy[3] !== 1'b0 || stall !== 1'b0) begin
            n_bad++; $display("FAIL wr_read_accept: got busy3=%b stall=%b expected 0 0", busy[3], stall); end
        idle(1);
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL wr_read_early: got %b expected 0", data_valid); end
        idle(1);
        n_cmp++; if (data_valid !== 1'b1 || data_out !== 16'hBEEF) begin
            n_bad++; $display("FAIL wr_read_data: got valid=%b data=%h expected 1 beef", data_valid, data_out); end
        idle(1);
        n_cmp++; if (data_valid !== 1'b0 || data_out !== 16'hBEEF) begin
            n_bad++; $display("FAIL wr_read_hold: got valid=%b data=%h expected 0 beef", data_valid, data_out); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat [4];
        pat[0] = 16'h1111; pat[1] = 16'h2222; pat[2] = 16'h3333; pat[3] = 16'h4444;
        idle(8);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 16'h0100 + 16'(2 * i), pat[i], 1);
            n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_wr_stall%0d: got %b expected 0", i, stall); end
        end
        idle(1);
        n_cmp++; if (busy !== 4'b1111) begin n_bad++; $display("FAIL b2b_busy_all: got %b expected 1111", busy); end
        idle(8);
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(1, 0, 16'h0100 + 16'(2 * c), 16'h0, 1);
            else idle(1);
            if (c < 4) begin
                n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_rd_stall%0d: got %b expected 0", c, stall); end
            end
            if (c >= 2) begin
                n_cmp++; if (data_valid !== 1'b1 || data_out !== pat[c-2]) begin
                    n_bad++; $display("FAIL b2b_rd_data%0d: got valid=%b data=%h expected 1 %h", c - 2, data_valid, data_out, pat[c-2]); end
            end else begin
                n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_rd_early%0d: got %b expected 0", c, data_valid); end
            end
        end
    endtask

    task automatic test_stall();
        int stalls;
        bit acc;
        stalls = 0;
        acc = 0;
        idle(8);
        drive(0, 1, 16'h0002, 16'h5A5A, 1);
        for (int i = 0; i < 10 && !acc; i++) begin
            drive(1, 0, 16'h000A, 16'h0, 1);
            n_cmp++; if (stall !== m_stall || busy[1] !== m_busy[1]) begin
                n_bad++; $display("FAIL stall_cycle%0d: got stall=%b busy1=%b expected %b %b", i, stall, busy[1], m_stall, m_busy[1]); end
            if (stall === 1'b0) acc = 1;
            else stalls++;
        end
        n_cmp++; if (!acc || stalls != BANK_CYCLES) begin
            n_bad++; $display("FAIL stall_count: got accepted=%0d stalls=%0d expected 1 %0d", acc, stalls, BANK_CYCLES); end
        idle(1);
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL stall_read_early: got %b expected 0", data_valid); end
        idle(1);
        n_cmp++; if (data_valid !== 1'b1 || data_out !== 16'h0000) begin
            n_bad++; $display("FAIL stall_read_data: got valid=%b data=%h expected 1 0000", data_valid, data_out); end
    endtask

    task automatic test_err();
        idle(8);
        drive(0, 1, 16'h0004, 16'h1234, 1);
        idle(6);
        drive(1, 1, 16'h0004, 16'hDEAD, 1);
        n_cmp++; if (err !== 1'b1 || stall !== 1'b0) begin
            n_bad++; $display("FAIL err_rdwr: got err=%b stall=%b expected 1 0", err, stall); end
        idle(1);
        n_cmp++; if (busy !== 4'b0000 || data_valid !== 1'b0) begin
            n_bad++; $display("FAIL err_rdwr_effect: got busy=%b valid=%b expected 0000 0", busy, data_valid); end
        drive(1, 0, 16'h0003, 16'h0, 1);
        n_cmp++; if (err !== 1'b1 || stall !== 1'b0) begin
            n_bad++; $display("FAIL err_odd: got err=%b stall=%b expected 1 0", err, stall); end
        idle(1);
        n_cmp++; if (busy !== 4'b0000 || data_valid !== 1'b0) begin
            n_bad++; $display("FAIL err_odd_effect: got busy=%b valid=%b expected 0000 0", busy, data_valid); end
        idle(1);
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL err_odd_late: got %b expected 0", data_valid); end
        drive(1, 0, 16'h0004, 16'h0, 1);
        idle(2);
        n_cmp++; if (data_valid !== 1'b1 || data_out !== 16'h1234) begin
            n_bad++; $display("FAIL err_no_write: got valid=%b data=%h expected 1 1234", data_valid, data_out); end
    endtask

    task automatic test_reset_mid();
        idle(8);
        drive(1, 0, 16'h0020, 16'h0, 1);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rstmid_accept: got %b expected 0", stall); end
        drive(0, 1, 16'h0030, 16'h7777, 0);
        drive(0, 0, 16'h0, 16'h0, 1);
        n_cmp++; if (data_valid !== 1'b0 || data_out !== 16'h0000 || busy !== 4'b0000) begin
            n_bad++; $display("FAIL rstmid_flush: got valid=%b data=%h busy=%b expected 0 0000 0000", data_valid, data_out, busy); end
        idle(2);
        drive(1, 0, 16'h0030, 16'h0, 1);
        idle(2);
        n_cmp++; if (data_valid !== 1'b1 || data_out !== 16'h0000) begin
            n_bad++; $display("FAIL rstmid_write_dropped: got valid=%b data=%h expected 1 0000", data_valid, data_out); end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic        r, w, rs;
        int          sel;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            r = (sel <= 3) || (sel == 7);
            w = (sel >= 4 && sel <= 7);
            a = 16'($urandom_range(0, 15)) << 1;
            a[15:13] = 3'($urandom_range(0, 7));
            a[12] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) a[0] = 1'b1;
            rs = ($urandom_range(0, 63) != 0);
            drive(r, w, a, 16'($urandom), rs);
            n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL rnd_err@%0d: got %b expected %b", cyc, err, m_err); end
            n_cmp++; if (stall !== m_stall) begin n_bad++; $display("FAIL rnd_stall@%0d: got %b expected %b", cyc, stall, m_stall); end
            n_cmp++; if (busy !== m_busy) begin n_bad++; $display("FAIL rnd_busy@%0d: got %b expected %b", cyc, busy, m_busy); end
            n_cmp++; if (data_valid !== m_dv) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, data_valid, m_dv); end
            n_cmp++; if (data_out !== m_dout) begin n_bad++; $display("FAIL rnd_data@%0d: got %h expected %h", cyc, data_out, m_dout); end
        end
        idle(3);
        n_cmp++; if (due_q.size() != 0) begin n_bad++; $display("FAIL rnd_drain: got %0d pending expected 0", due_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_stall();
        test_err();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
